// File: rtl/operand_fetch_stage.sv
// RV32I ID->EX stage: register-file address drive, WB->ID operand bypass,
// immediate generation, load-use bubble insertion and the EX pipeline register.
module operand_fetch_stage #(
    parameter bit BYPASS_EN = 1'b1,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        stall_in,
    input  logic        flush,
    output logic        stall_out,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_instr,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_imm,
    output logic        ex_mem_read
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic        uses_rs1, uses_rs2, is_load;
    logic [31:0] imm, op1, op2;
    logic        hazard;

    assign opcode = if_instr[6:0];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rf_a1  = rs1;
    assign rf_a2  = rs2;

    assign is_load  = (opcode == OP_LOAD);
    assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign uses_rs2 = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);

    always_comb begin
        imm = 32'd0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{20{if_instr[31]}}, if_instr[31:20]};
            OP_STORE:
                imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH:
                imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                       if_instr[30:25], if_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {if_instr[31:12], 12'd0};
            OP_JAL:
                imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                       if_instr[20], if_instr[30:21], 1'b0};
            default:
                imm = 32'd0;
        endcase
    end

    // The register file writes at the edge, so a same-cycle read is stale: forward wb_data.
    assign op1 = (BYPASS_EN && wb_we && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : rf_rd1;
    assign op2 = (BYPASS_EN && wb_we && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rf_rd2;

    assign hazard = HAZARD_EN && if_valid && ex_valid && ex_mem_read && ex_rd != 5'd0 &&
                    ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));

    assign stall_out = !flush && (stall_in || hazard);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= 32'd0;
            ex_instr    <= 32'd0;
            ex_rs1_val  <= 32'd0;
            ex_rs2_val  <= 32'd0;
            ex_rd       <= 5'd0;
            ex_imm      <= 32'd0;
            ex_mem_read <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!stall_in) begin
            if (hazard) begin
                ex_valid    <= 1'b0;
                ex_mem_read <= 1'b0;
            end else begin
                ex_valid    <= if_valid;
                ex_pc       <= if_pc;
                ex_instr    <= if_instr;
                ex_rs1_val  <= op1;
                ex_rs2_val  <= op2;
                ex_rd       <= if_instr[11:7];
                ex_imm      <= imm;
                ex_mem_read <= is_load;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios plus randomized
// traffic scored against a spec-level reference model.
module tb_operand_fetch_stage;

    logic        clock, reset;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_in, flush, stall_out;
    logic        ex_valid, ex_mem_read;
    logic [31:0] ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;

    int tests = 0;
    int fails = 0;

    // reference model of the EX register
    logic        m_valid, m_mr;
    logic [31:0] m_pc, m_instr, m_rs1, m_rs2, m_imm;
    logic [4:0]  m_rd;

    operand_fetch_stage dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_in(stall_in), .flush(flush), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_mem_read(ex_mem_read)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        logic [31:0] sx;
        sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: return (sx & 32'hFFFF_F000) | (i >> 20);
            7'b0100011: return (sx & 32'hFFFF_F000) | ((i >> 20) & 32'hFE0) | ((i >> 7) & 32'h1F);
            7'b1100011: return (sx & 32'hFFFF_F000) | (((i >> 7) & 1) << 11) |
                               (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
            7'b0110111, 7'b0010111: return i & 32'hFFFF_F000;
            7'b1101111: return (sx & 32'hFFF0_0000) | (i & 32'h000F_F000) |
                               (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3FF) << 1);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_uses1(input logic [31:0] i);
        return !(i[6:0] == 7'b0110111 || i[6:0] == 7'b0010111 || i[6:0] == 7'b1101111);
    endfunction

    function automatic logic ref_uses2(input logic [31:0] i);
        return i[6:0] == 7'b0110011 || i[6:0] == 7'b0100011 || i[6:0] == 7'b1100011;
    endfunction

    function automatic logic ref_hazard();
        logic [4:0] s1, s2;
        s1 = if_instr[19:15];
        s2 = if_instr[24:20];
        return if_valid && m_valid && m_mr && m_rd != 0 &&
               ((ref_uses1(if_instr) && m_rd == s1) || (ref_uses2(if_instr) && m_rd == s2));
    endfunction

    function automatic logic ref_stall();
        return !flush && (stall_in || ref_hazard());
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rd);
        return (wb_we && wb_rd != 0 && wb_rd == a) ? wb_data : rd;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_mr = 0; m_pc = 0; m_instr = 0;
        m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
    endtask

    // one rising edge: advance the model with the inputs sampled at that edge
    task automatic tick();
        logic haz;
        @(posedge clock);
        haz = ref_hazard();
        if (flush) m_valid = 0;
        else if (stall_in) ;
        else if (haz) begin
            m_valid = 0; m_mr = 0;
        end else begin
            m_valid = if_valid;
            m_pc    = if_pc;
            m_instr = if_instr;
            m_rs1   = ref_operand(if_instr[19:15], rf_rd1);
            m_rs2   = ref_operand(if_instr[24:20], rf_rd2);
            m_rd    = if_instr[11:7];
            m_imm   = ref_imm(if_instr);
            m_mr    = (if_instr[6:0] == 7'b0000011);
        end
        #1;
    endtask

    task automatic idle_inputs();
        if_valid = 0; if_instr = 32'h0000_0013; if_pc = 0;
        rf_rd1 = 0; rf_rd2 = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        stall_in = 0; flush = 0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1; if_instr = instr; if_pc = pc;
    endtask

    task automatic test_reset();
        logic [179:0] all_ex;
        idle_inputs();
        reset = 1;
        model_reset();
        #3;
        all_ex = {ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_mem_read};
        tests++;
        if (all_ex !== '0) begin
            fails++; $display("FAIL reset_init: ex regs=%h want 0", all_ex);
        end
        @(negedge clock); reset = 0;
        issue(32'h0000A283, 32'h100); rf_rd1 = 32'h55;
        tick();
        stall_in = 1;           // mid-stall, then drop stall and pulse reset between edges
        tick();
        stall_in = 0;
        #2 reset = 1; model_reset();
        #1;
        all_ex = {ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_mem_read};
        tests++;
        if (all_ex !== '0) begin
            fails++; $display("FAIL reset_mid: ex regs=%h want 0", all_ex);
        end
        tests++;
        if (stall_out !== 1'b0) begin
            fails++; $display("FAIL reset_stall_out: got %b want 0", stall_out);
        end
        #1 reset = 0;
        idle_inputs();
        tick();
    endtask

    task automatic test_bypass();
        idle_inputs();
        issue(32'h006283B3, 32'h200);
        rf_rd1 = 32'h11; rf_rd2 = 32'h22;
        wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        #1;
        tests++;
        if (rf_a1 !== 5'd5 || rf_a2 !== 5'd6) begin
            fails++; $display("FAIL rf_addr: got %0d,%0d want 5,6", rf_a1, rf_a2);
        end
        tick();
        tests++;
        if (ex_rs1_val !== 32'hDEADBEEF) begin
            fails++; $display("FAIL bypass_rs1: got %h want deadbeef", ex_rs1_val);
        end
        tests++;
        if (ex_rs2_val !== 32'h22 || ex_rd !== 5'd7 || ex_valid !== 1'b1) begin
            fails++; $display("FAIL bypass_rest: rs2=%h rd=%0d v=%b want 22,7,1", ex_rs2_val, ex_rd, ex_valid);
        end
    endtask

    task automatic test_x0();
        idle_inputs();
        issue(32'h00600333, 32'h204);   // add x6, x0, x6
        rf_rd1 = 32'h11; rf_rd2 = 32'h22;
        wb_we = 1; wb_rd = 0; wb_data = 32'hDEADBEEF;
        tick();
        tests++;
        if (ex_rs1_val !== 32'h11) begin
            fails++; $display("FAIL x0_bypass: got %h want 11", ex_rs1_val);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        issue(32'h0000A283, 32'h300);
        tick();
        issue(32'h006283B3, 32'h304);
        #1;
        tests++;
        if (stall_out !== 1'b1) begin
            fails++; $display("FAIL lu_stall: got %b want 1", stall_out);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b0 || stall_out !== 1'b0) begin
            fails++; $display("FAIL lu_bubble: v=%b stall=%b want 0,0", ex_valid, stall_out);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_pc !== 32'h304) begin
            fails++; $display("FAIL lu_issue: v=%b rd=%0d pc=%h want 1,7,304", ex_valid, ex_rd, ex_pc);
        end
    endtask

    task automatic test_flush_stall();
        logic [179:0] snap, now;
        idle_inputs();
        issue(32'h0000A283, 32'h400);
        tick();
        issue(32'h006283B3, 32'h404);
        flush = 1;
        #1;
        tests++;
        if (stall_out !== 1'b0) begin
            fails++; $display("FAIL flush_stall_out: got %b want 0", stall_out);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b0) begin
            fails++; $display("FAIL flush_kill: ex_valid=%b want 0", ex_valid);
        end
        flush = 0;
        issue(32'h00A00093, 32'h408);   // addi x1, x0, 10
        tick();
        snap = {ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_mem_read};
        stall_in = 1;
        for (int c = 0; c < 3; c++) begin
            issue($urandom, $urandom); rf_rd1 = $urandom; rf_rd2 = $urandom;
            #1;
            tests++;
            if (stall_out !== 1'b1) begin
                fails++; $display("FAIL stall_in_out: cyc %0d got %b want 1", c, stall_out);
            end
            tick();
            now = {ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_mem_read};
            tests++;
            if (now !== snap || ex_pc !== 32'h408) begin
                fails++; $display("FAIL stall_in_hold: cyc %0d got %h want %h", c, now, snap);
            end
        end
        stall_in = 0;
    endtask

    task automatic test_immediate();
        idle_inputs();
        issue(32'hFE20AE23, 32'h500);
        tick();
        tests++;
        if (ex_imm !== 32'hFFFFFFFC || ex_mem_read !== 1'b0) begin
            fails++; $display("FAIL imm_sw: imm=%h mr=%b want fffffffc,0", ex_imm, ex_mem_read);
        end
        issue(32'h0000A283, 32'h504);
        tick();
        tests++;
        if (ex_imm !== 32'h0 || ex_mem_read !== 1'b1) begin
            fails++; $display("FAIL imm_lw: imm=%h mr=%b want 0,1", ex_imm, ex_mem_read);
        end
        issue(32'h0000A283, 32'h508);   // x0-free dependency check not needed; drain
        if_valid = 0;
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] r;
        ops = '{7'b0000011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0110011, 7'b1110011};
        r = $urandom;
        r[6:0]   = ops[$urandom_range(0, 11)];
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    task automatic test_random();
        logic [179:0] got, exp;
        idle_inputs();
        for (int c = 0; c < 500; c++) begin
            if_valid = ($urandom_range(0, 9) < 8);
            if_instr = rand_instr();
            if_pc    = $urandom;
            rf_rd1   = $urandom; rf_rd2 = $urandom;
            wb_we    = $urandom_range(0, 1);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            stall_in = ($urandom_range(0, 9) < 2);
            flush    = ($urandom_range(0, 19) == 0);
            #1;
            tests++;
            if (stall_out !== ref_stall() || rf_a1 !== if_instr[19:15] || rf_a2 !== if_instr[24:20]) begin
                fails++;
                $display("FAIL rand_comb: cyc %0d stall=%b a1=%0d a2=%0d want %b,%0d,%0d",
                         c, stall_out, rf_a1, rf_a2, ref_stall(), if_instr[19:15], if_instr[24:20]);
            end
            tick();
            got = {ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_rd, ex_imm, ex_mem_read};
            exp = {m_valid, m_pc, m_instr, m_rs1, m_rs2, m_rd, m_imm, m_mr};
            tests++;
            if (got !== exp) begin
                fails++; $display("FAIL rand_ex: cyc %0d got %h want %h", c, got, exp);
            end
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_bypass();
        test_x0();
        test_load_use();
        test_flush_stall();
        test_immediate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
